// File: rtl/frame_serializer_pkg.sv
// Shared constants and helpers for the framed-word serializer.
// Frame layout is {marker, payload[2:0], marker}; both markers must be 1.
package frame_pkg;

  localparam int FRAME_W       = 5;
  localparam int MARKER_HI_IDX = 4;
  localparam int MARKER_LO_IDX = 0;

  localparam logic IDLE_LEVEL = 1'b0;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_SHIFT = 2'd1;
  localparam state_t ST_GAP   = 2'd2;

  function automatic logic markers_ok(input logic [FRAME_W-1:0] w);
    return w[MARKER_HI_IDX] & w[MARKER_LO_IDX];
  endfunction

endpackage

// File: rtl/frame_serializer_if.sv
// Valid/ready word handshake between the encoding stage and the serializer.
interface frame_serializer_if;
  import frame_pkg::*;

  logic               in_valid;
  logic [FRAME_W-1:0] in_word;
  logic               in_ready;

  modport master (output in_valid, output in_word, input in_ready);
  modport slave  (input in_valid, input in_word, output in_ready);

endinterface

// File: rtl/frame_serializer_bit_timer.sv
// Loadable down-counter; tc flags the last enabled cycle of a loaded period.
module bit_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             tc
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  assign tc = en && (count_q == '0);

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (en && (count_q != '0)) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/frame_serializer.sv
// Serializes a marker-checked 5-bit framed word MSB-first, each bit held
// BIT_DIV clocks, followed by GAP_BITS idle bit-times.
module frame_serializer
  import frame_pkg::*;
#(
  parameter int BIT_DIV  = 4,
  parameter int GAP_BITS = 1,
  parameter int W        = FRAME_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  frame_serializer_if.slave        up,
  output logic                     ser_out,
  output logic                     busy,
  output logic                     frame_err,
  output logic [7:0]               sent_count
);

  localparam int           GAP_CYC  = GAP_BITS * BIT_DIV;
  localparam logic [7:0]   DIV_LOAD = 8'(BIT_DIV - 1);
  localparam logic [11:0]  GAP_LOAD = (GAP_CYC > 0) ? 12'(GAP_CYC - 1) : 12'd0;
  localparam logic [2:0]   LAST_BIT = 3'(W - 1);

  state_t        state_q, state_d;
  logic [W-1:0]  shift_q, shift_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic          ser_q, ser_d;
  logic          err_q, err_d;
  logic          rdy_q, rdy_d;
  logic [7:0]    cnt_q, cnt_d;

  logic          div_load, div_en, div_tc;
  logic          gap_load, gap_en, gap_tc;
  logic          accept;

  bit_timer #(.CNT_W(8)) u_div_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (div_load),
    .load_val (DIV_LOAD),
    .en       (div_en),
    .tc       (div_tc)
  );

  bit_timer #(.CNT_W(12)) u_gap_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (gap_load),
    .load_val (GAP_LOAD),
    .en       (gap_en),
    .tc       (gap_tc)
  );

  assign accept = rdy_q && up.in_valid && (state_q == ST_IDLE);

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    ser_d     = ser_q;
    err_d     = 1'b0;
    cnt_d     = cnt_q;
    div_load  = 1'b0;
    div_en    = 1'b0;
    gap_load  = 1'b0;
    gap_en    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        ser_d = IDLE_LEVEL;
        if (accept) begin
          if (markers_ok(up.in_word)) begin
            // ser_out carries the first bit on the cycle right after acceptance
            shift_d   = up.in_word;
            bit_cnt_d = '0;
            div_load  = 1'b1;
            ser_d     = up.in_word[W-1];
            state_d   = ST_SHIFT;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      ST_SHIFT: begin
        div_en = 1'b1;
        if (div_tc) begin
          if (bit_cnt_q == LAST_BIT) begin
            cnt_d   = cnt_q + 8'd1;
            ser_d   = IDLE_LEVEL;
            shift_d = '0;
            if (GAP_BITS > 0) begin
              state_d  = ST_GAP;
              gap_load = 1'b1;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            shift_d   = shift_q << 1;
            ser_d     = shift_q[W-2];
            bit_cnt_d = bit_cnt_q + 3'd1;
            div_load  = 1'b1;
          end
        end
      end

      ST_GAP: begin
        gap_en = 1'b1;
        ser_d  = IDLE_LEVEL;
        if (gap_tc) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        ser_d   = IDLE_LEVEL;
      end
    endcase

    // Registered so in_ready stays low through reset and rises after release.
    rdy_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      ser_q     <= IDLE_LEVEL;
      err_q     <= 1'b0;
      rdy_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      ser_q     <= ser_d;
      err_q     <= err_d;
      rdy_q     <= rdy_d;
      cnt_q     <= cnt_d;
    end
  end

  assign up.in_ready = rdy_q;
  assign ser_out     = ser_q;
  assign busy        = (state_q != ST_IDLE);
  assign frame_err   = err_q;
  assign sent_count  = cnt_q;

endmodule
